ysyx_22040088_pcgen: RTL and testbench
======================================

# ysyx_22040088_pcgen

Parametrised program-counter generator for the NPC fetch stage. It holds the architectural fetch PC and drives it to the IFU over a valid/ready handshake. It advances sequentially on each accepted fetch and takes redirects from N one-hot-encoded sources, resolving conflicts by fixed priority. Misaligned redirect targets halt fetch until the trap source steers it back. It sits between the branch/jump resolution logic and the IFU, replacing the purely combinational next-PC mux.

## Interface

Parameters:
- XLEN, 64, PC width in bits.
- NSRC, 6, number of redirect sources; index 0 has the highest priority.
- TRAP_SRC, 0, index of the redirect source that may leave HALT (trap/mtvec/mepc path).
- RESET_PC, 64'h8000_0000, PC loaded by reset.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- redir_sel  in  NSRC  redirect request per source; multiple bits may be set.
- redir_pc  in  NSRC*XLEN  target per source; source i occupies bits [i*XLEN +: XLEN].
- ilen_c  in  1  the instruction just accepted was 16-bit; only used when RVC is compiled in.
- pc_valid  out  1  pc is a fetch request.
- pc_ready  in  1  the IFU accepts the request this cycle.
- pc  out  XLEN  current fetch PC.
- halted  out  1  high while in HALT.
- bad_target  out  XLEN  the misaligned target that caused HALT.

## Operation

- States: BOOT, RUN, HALT. The state is encoded in 2 bits.
- Redirect selection: win = the lowest set index of redir_sel. tgt = redir_pc[win]. A redirect is present when any redir_sel bit is set.
- Alignment: tgt is misaligned if tgt[1:0] != 0. With RVC compiled in, tgt is misaligned if tgt[0] != 0.
- Sequential increment: inc = 4. With RVC compiled in, inc = ilen_c ? 2 : 4.
- Addition wraps modulo 2^XLEN. No carry out is kept.

BOOT (entered by reset):
- pc_valid = 0.
- An aligned redirect loads tgt. Otherwise pc is unchanged.
- The next state is always RUN, except that a misaligned redirect goes to HALT.

RUN:
- pc_valid = 1.
- A redirect acts as a flush and takes effect regardless of pc_ready. An aligned tgt loads pc = tgt. A misaligned tgt goes to HALT with bad_target = tgt, and pc is unchanged.
- With no redirect, a handshake (pc_valid & pc_ready) loads pc = pc + inc.
- With neither a redirect nor a handshake, pc holds.
- A redirect and a handshake in the same cycle: the redirect wins and pc + inc is discarded.

HALT:
- pc_valid = 0 and halted = 1. bad_target holds its value.
- Only a redirect with win == TRAP_SRC and an aligned tgt is honoured. It loads pc = tgt and the next state is RUN.
- A redirect from any other source is ignored, even if a trap-source bit is also set at a lower priority.
- A misaligned trap target keeps the block in HALT and updates bad_target.

Reset:
- pc = RESET_PC, pc_valid = 0, halted = 0, bad_target = 0, state = BOOT.
- Reset dominates all inputs in the same cycle, including mid-handshake and mid-HALT.

## Timing

- All outputs are registered or decoded from the state; there are no combinational input-to-output paths.
- Redirect latency: redir_sel is sampled at edge N, and the new pc is visible after edge N, one cycle.
- The first fetch request appears one cycle after rst deasserts.
- While pc_valid is high and no redirect occurs, pc is stable until the handshake.
- Back-to-back handshakes advance pc every cycle.
- HALT is entered on the edge that samples the bad redirect, and pc_valid drops in the same cycle that halted rises.

## Configuration

- YSYX_22040088_RVC_EN defined:
  - 16-bit alignment check on targets (tgt[0] only).
  - ilen_c selects an increment of 2 or 4.
- YSYX_22040088_RVC_EN undefined:
  - 32-bit alignment check on targets (tgt[1:0]).
  - ilen_c is ignored and the increment is always 4.
  - Any target with tgt[1] set halts.

## Test plan

- **Reset:** hold rst for 3 cycles, then release with pc_ready = 1. Expect pc = 8000_0000 and pc_valid = 0 in the first cycle. Then expect pc_valid = 1 with pc = 8000_0000, 8000_0004, 8000_0008 on successive cycles.
- **Stall:** hold pc_ready = 0 for 4 cycles. pc stays at 8000_0008 with pc_valid = 1. Then raise pc_ready and pc advances to 8000_000C.
- **Priority and redirect-while-stalled:**
  - Set redir_sel = 6'b010100, with source 2 = 8000_0100 and source 4 = 8000_0200, while pc_ready = 0. Next cycle pc = 8000_0100.
  - Repeat with a simultaneous handshake. The redirect still wins.
- **Misaligned target, RVC off:** source 3 targets 8000_0102. Expect halted = 1, pc_valid = 0, bad_target = 8000_0102.
  - A redirect from source 1 is ignored.
  - A redirect from source 0 to 8000_0400 resumes RUN with pc = 8000_0400 one cycle later.
- **RVC on:**
  - Handshakes with ilen_c = 1,1,0 from 8000_0000 give pc = 8000_0002, 8000_0004, 8000_0008.
  - A target of 8000_0102 is accepted.
  - A target of 8000_0101 halts.
- **Wrap and reset mid-HALT:**
  - A redirect to FFFF_FFFF_FFFF_FFFC followed by a handshake gives pc = 0.
  - Asserting rst while in HALT gives halted = 0, bad_target = 0, pc = 8000_0000 the next cycle.

Source files
------------

// File: rtl/ysyx_22040088_pcgen.sv
// Fetch program-counter generator: holds the fetch PC, steps it on IFU handshakes, and takes prioritised redirects.
// Latency: one cycle from redirect or handshake to the new pc; all outputs are registered or decoded from state.
// Backpressure: pc is held while pc_valid & !pc_ready; redirects flush regardless of pc_ready.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   redir_sel       one request bit per redirect source (index 0 = highest priority)
//   redir_pc        packed targets, source i at [i*XLEN +: XLEN]
//   ilen_c          accepted instruction was 16-bit (only with compressed support)
//   pc_valid/ready  fetch request handshake towards the IFU
//   pc              current fetch PC
//   halted          fetch stopped on a misaligned target
//   bad_target      the misaligned target that caused the halt
//
// Optional feature macro: YSYX_22040088_RVC_EN enables 16-bit alignment and 2/4-byte increments.
module ysyx_22040088_pcgen #(
    parameter int              XLEN     = 64,
    parameter int              NSRC     = 6,
    parameter int              TRAP_SRC = 0,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   redir_sel,
    input  logic [NSRC*XLEN-1:0] redir_pc,
    input  logic              ilen_c,
    output logic              pc_valid,
    input  logic              pc_ready,
    output logic [XLEN-1:0]   pc,
    output logic              halted,
    output logic [XLEN-1:0]   bad_target
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [IDXW-1:0] TRAP_IDX = IDXW'(TRAP_SRC);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_q, bad_d;

    logic [IDXW-1:0] win;
    logic [XLEN-1:0] tgt;
    logic            has_redir;
    logic            misal;
    logic [XLEN-1:0] inc;

    // Priority pick: scan from the lowest priority upwards so the lowest set index is the last write.
    always_comb begin
        win = '0;
        tgt = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (redir_sel[i]) begin
                win = IDXW'(i);
                tgt = redir_pc[i*XLEN +: XLEN];
            end
        end
    end

    assign has_redir = |redir_sel;

`ifdef YSYX_22040088_RVC_EN
    assign misal = tgt[0];
    assign inc   = ilen_c ? XLEN'(2) : XLEN'(4);
`else
    // Without compressed instructions the length hint carries no information.
    logic unused_ilen_c;
    assign unused_ilen_c = ilen_c;
    assign misal = |tgt[1:0];
    assign inc   = XLEN'(4);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (has_redir) begin
                    if (misal) begin
                        state_d = ST_HALT;
                        bad_d   = tgt;
                    end else begin
                        pc_d = tgt;
                    end
                end
            end
            ST_RUN: begin
                // A redirect is a flush: it overrides any handshake in the same cycle.
                if (has_redir) begin
                    if (misal) begin
                        state_d = ST_HALT;
                        bad_d   = tgt;
                    end else begin
                        pc_d = tgt;
                    end
                end else if (pc_ready) begin
                    pc_d = pc_q + inc;
                end
            end
            ST_HALT: begin
                // Only the trap path may leave HALT, and only if it actually wins arbitration.
                if (has_redir && (win == TRAP_IDX)) begin
                    if (misal) begin
                        bad_d = tgt;
                    end else begin
                        pc_d    = tgt;
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
        end
    end

    assign pc_valid   = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALT);
    assign pc         = pc_q;
    assign bad_target = bad_q;

endmodule

// File: tb/tb_ysyx_22040088_pcgen.sv
// Self-checking bench for ysyx_22040088_pcgen with default parameters.
// Each scenario task queues the expected post-edge outputs and compares them after the edge.
// Build with or without YSYX_22040088_RVC_EN; the compressed-length scenarios follow that macro.
module tb_ysyx_22040088_pcgen;

    localparam logic [63:0] RST = 64'h8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        redir_sel;
    logic [6*64-1:0]   redir_pc;
    logic              ilen_c;
    logic              pc_valid;
    logic              pc_ready;
    logic [63:0]       pc;
    logic              halted;
    logic [63:0]       bad_target;

    always #5 clk = ~clk;

    ysyx_22040088_pcgen dut (
        .clk        (clk),
        .rst        (rst),
        .redir_sel  (redir_sel),
        .redir_pc   (redir_pc),
        .ilen_c     (ilen_c),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .pc         (pc),
        .halted     (halted),
        .bad_target (bad_target)
    );

    typedef struct packed {
        logic        v;
        logic        h;
        logic [63:0] p;
        logic [63:0] b;
    } obs_t;

    typedef struct packed {
        logic             rs;
        logic             rd;
        logic             il;
        logic [5:0]       sel;
        logic [5:0][63:0] tgt;
    } row_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic row_t mk(input logic rs, input logic rd, input logic il, input logic [5:0] sel,
                                input int ia, input logic [63:0] ta, input int ib, input logic [63:0] tb);
        row_t r;
        r     = '0;
        r.rs  = rs;
        r.rd  = rd;
        r.il  = il;
        r.sel = sel;
        if (ia >= 0) r.tgt[ia] = ta;
        if (ib >= 0) r.tgt[ib] = tb;
        return r;
    endfunction

    function automatic obs_t ob(input logic v, input logic h, input logic [63:0] p, input logic [63:0] b);
        return obs_t'({v, h, p, b});
    endfunction

    // Apply one stimulus row and queue the outputs expected after the next edge.
    task automatic drive(input row_t r, input obs_t e);
        rst       = r.rs;
        pc_ready  = r.rd;
        ilen_c    = r.il;
        redir_sel = r.sel;
        redir_pc  = r.tgt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            r.push_back(mk(1, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(0, 0, RST, 0));
        end
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST, 0));
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 4, 0));
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 8, 0));
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    task automatic test_stall();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        for (int i = 0; i < 4; i++) begin
            r.push_back(mk(0, 0, 1, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 8, 0));
        end
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 12, 0));
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    task automatic test_priority();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        // Stalled: sources 2 and 4 both request, 2 wins.
        r.push_back(mk(0, 0, 0, 6'b010100, 2, RST + 64'h100, 4, RST + 64'h200)); x.push_back(ob(1, 0, RST + 64'h100, 0));
        // Same with a handshake: redirect wins over pc + 4.
        r.push_back(mk(0, 1, 0, 6'b010100, 2, RST + 64'h180, 4, RST + 64'h200)); x.push_back(ob(1, 0, RST + 64'h180, 0));
        r.push_back(mk(0, 1, 0, 6'b000011, 0, RST + 64'h1C0, 1, RST + 64'h1E0)); x.push_back(ob(1, 0, RST + 64'h1C0, 0));
        r.push_back(mk(0, 0, 0, 6'b100000, 5, RST + 64'h1F0, -1, 0));            x.push_back(ob(1, 0, RST + 64'h1F0, 0));
        r.push_back(mk(0, 0, 0, 6'b000000, -1, 0, -1, 0));                       x.push_back(ob(1, 0, RST + 64'h1F0, 0));
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL priority step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    task automatic test_misaligned();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        logic [63:0] badt, cur;
`ifdef YSYX_22040088_RVC_EN
        badt = RST + 64'h101;
`else
        badt = RST + 64'h102;
`endif
        cur = RST + 64'h1F0;
        r.push_back(mk(0, 1, 0, 6'b001000, 3, badt, -1, 0));                x.push_back(ob(0, 1, cur, badt));
        r.push_back(mk(0, 1, 0, 6'b000010, 1, RST + 64'h500, -1, 0));       x.push_back(ob(0, 1, cur, badt));
        r.push_back(mk(0, 1, 0, 6'b000001, 0, RST + 64'h3, -1, 0));         x.push_back(ob(0, 1, cur, RST + 64'h3));
        r.push_back(mk(0, 1, 0, 6'b000000, -1, 0, -1, 0));                  x.push_back(ob(0, 1, cur, RST + 64'h3));
        r.push_back(mk(0, 0, 0, 6'b000011, 0, RST + 64'h400, 1, RST + 64'h4)); x.push_back(ob(1, 0, RST + 64'h400, RST + 64'h3));
        r.push_back(mk(0, 0, 0, 6'b000000, -1, 0, -1, 0));                  x.push_back(ob(1, 0, RST + 64'h400, RST + 64'h3));
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL misaligned step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    task automatic test_ilen();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        logic [63:0] b;
        b = RST + 64'h3;
        r.push_back(mk(0, 0, 0, 6'b000001, 0, RST, -1, 0)); x.push_back(ob(1, 0, RST, b));
`ifdef YSYX_22040088_RVC_EN
        r.push_back(mk(0, 1, 1, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 2, b));
        r.push_back(mk(0, 1, 1, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 4, b));
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 8, b));
        r.push_back(mk(0, 0, 0, 6'b000100, 2, RST + 64'h102, -1, 0)); x.push_back(ob(1, 0, RST + 64'h102, b));
`else
        r.push_back(mk(0, 1, 1, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 4, b));
        r.push_back(mk(0, 1, 1, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 8, b));
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, RST + 12, b));
`endif
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ilen step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    task automatic test_wrap();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        logic [63:0] b;
        b = RST + 64'h3;
        r.push_back(mk(0, 0, 0, 6'b000001, 0, 64'hFFFF_FFFF_FFFF_FFFC, -1, 0)); x.push_back(ob(1, 0, 64'hFFFF_FFFF_FFFF_FFFC, b));
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, 64'h0, b));
        r.push_back(mk(0, 0, 0, 6'b0, -1, 0, -1, 0)); x.push_back(ob(1, 0, 64'h0, b));
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    task automatic test_reset_halt();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        r.push_back(mk(0, 1, 0, 6'b000001, 0, RST + 64'h7, -1, 0));   x.push_back(ob(0, 1, 64'h0, RST + 64'h7));
        // Reset wins over a simultaneous trap redirect and handshake.
        r.push_back(mk(1, 1, 0, 6'b000001, 0, RST + 64'h800, -1, 0)); x.push_back(ob(0, 0, RST, 0));
        r.push_back(mk(0, 0, 0, 6'b0, -1, 0, -1, 0));                 x.push_back(ob(1, 0, RST, 0));
        r.push_back(mk(0, 0, 0, 6'b0, -1, 0, -1, 0));                 x.push_back(ob(1, 0, RST, 0));
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_halt step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    task automatic test_boot_redirect();
        row_t r[$]; obs_t x[$]; obs_t e, o;
        r.push_back(mk(1, 0, 0, 6'b0, -1, 0, -1, 0));                   x.push_back(ob(0, 0, RST, 0));
        r.push_back(mk(0, 0, 0, 6'b100000, 5, RST + 64'h600, -1, 0));   x.push_back(ob(1, 0, RST + 64'h600, 0));
        r.push_back(mk(1, 0, 0, 6'b0, -1, 0, -1, 0));                   x.push_back(ob(0, 0, RST, 0));
        r.push_back(mk(0, 1, 0, 6'b010000, 4, RST + 64'h3, -1, 0));     x.push_back(ob(0, 1, RST, RST + 64'h3));
        r.push_back(mk(0, 1, 0, 6'b0, -1, 0, -1, 0));                   x.push_back(ob(0, 1, RST, RST + 64'h3));
        r.push_back(mk(0, 0, 0, 6'b000001, 0, RST + 64'h40, -1, 0));    x.push_back(ob(1, 0, RST + 64'h40, RST + 64'h3));
        for (int k = 0; k < r.size(); k++) begin
            drive(r[k], x[k]);
            e = exp_q.pop_front();
            o = {pc_valid, halted, pc, bad_target};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL boot step %0d: got v=%b h=%b pc=%h bad=%h want v=%b h=%b pc=%h bad=%h",
                         k, o.v, o.h, o.p, o.b, e.v, e.h, e.p, e.b);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        pc_ready  = 1'b0;
        ilen_c    = 1'b0;
        redir_sel = '0;
        redir_pc  = '0;
        test_reset();
        test_stall();
        test_priority();
        test_misaligned();
        test_ilen();
        test_wrap();
        test_reset_halt();
        test_boot_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
